// File: rtl/alu_control_sekuencial.sv
// alu_control_sekuencial
//
// Registered ALU control decoder for the execute stage. Turns the ALUOp/Funct
// pair coming from decode into an ALU operation code. Multi-cycle operations
// (mul, and ror when ROR_CYCLES > 1) keep their code on Operacioni for N
// cycles and raise Stall so that upstream holds the next instruction.
//
// Parameters
//   FUNCT_W     Funct field width (>= 4); any set bit above bit 3 is illegal
//   OP_W        operation code width (>= 4); codes zero-extended, NOP = all ones
//   MUL_CYCLES  cycles the mul code is held (>= 1)
//   ROR_CYCLES  cycles the ror code is held (>= 1)
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-high reset
//   In_Valid    in   ALUOp/Funct carry a new instruction this cycle
//   ALUOp       in   2-bit class: 00 add, 01 sub, 10 R-type, 11 illegal
//   Funct       in   R-type function field
//   Operacioni  out  registered ALU operation code
//   Out_Valid   out  Operacioni is a live operation this cycle
//   Done        out  last cycle of the current operation
//   Stall       out  registered; upstream must hold its instruction
//   Illegal     out  registered one-cycle pulse for an undecodable instruction

module alu_control_sekuencial #(
    parameter int FUNCT_W    = 4,
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int ROR_CYCLES = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               In_Valid,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    output logic [OP_W-1:0]    Operacioni,
    output logic               Out_Valid,
    output logic               Done,
    output logic               Stall,
    output logic               Illegal
);

    localparam int MAX_CYCLES = (MUL_CYCLES > ROR_CYCLES) ? MUL_CYCLES : ROR_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [OP_W-1:0]    NOP     = '1;
    // Bits of Funct above bit 3; empty when FUNCT_W == 4.
    localparam logic [FUNCT_W-1:0] HI_MASK = ~(FUNCT_W'(4'hF));

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             dec_legal;
    logic [OP_W-1:0]  dec_code;
    logic [CNT_W-1:0] dec_n;
    logic             funct_hi;

    assign funct_hi = |(Funct & HI_MASK);

    always_comb begin
        dec_legal = 1'b1;
        dec_code  = NOP;
        dec_n     = CNT_W'(1);
        case (ALUOp)
            2'b00: dec_code = OP_W'(4'b0100);
            2'b01: dec_code = OP_W'(4'b1100);
            2'b10: begin
                if (funct_hi) begin
                    dec_legal = 1'b0;
                end else begin
                    case (Funct[3:0])
                        4'b0000: dec_code = OP_W'(4'b0000);
                        4'b0001: dec_code = OP_W'(4'b0010);
                        4'b0010: dec_code = OP_W'(4'b0011);
                        4'b0011: begin
                            dec_code = OP_W'(4'b0110);
                            dec_n    = CNT_W'(ROR_CYCLES);
                        end
                        4'b0100: begin
                            dec_code = OP_W'(4'b0111);
                            dec_n    = CNT_W'(MUL_CYCLES);
                        end
                        4'b0101: dec_code = OP_W'(4'b0101);
                        default: dec_legal = 1'b0;
                    endcase
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            Operacioni <= NOP;
            Out_Valid  <= 1'b0;
            Stall      <= 1'b0;
            Illegal    <= 1'b0;
        end else begin
            Illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        if (dec_legal) begin
                            Operacioni <= dec_code;
                            Out_Valid  <= 1'b1;
                            // Ops held for a single cycle never enter HOLD.
                            if (dec_n > CNT_W'(1)) begin
                                state <= HOLD;
                                cnt   <= dec_n - CNT_W'(1);
                                Stall <= 1'b1;
                            end
                        end else begin
                            Operacioni <= NOP;
                            Out_Valid  <= 1'b0;
                            Illegal    <= 1'b1;
                        end
                    end else begin
                        Out_Valid <= 1'b0;
                    end
                end
                HOLD: begin
                    // Inputs are ignored; the held code and Out_Valid stay put.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        Stall <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The final cycle of an op is the first one back in IDLE, so an
    // instruction waiting on the inputs is taken at that edge.
    assign Done = Out_Valid & (state == IDLE);

endmodule

// File: tb/tb_alu_control_sekuencial.sv
module tb_alu_control_sekuencial;

    logic       Clock;
    logic       Reset;
    logic       In_Valid;
    logic [1:0] ALUOp;
    logic [5:0] Funct;
    logic [3:0] Operacioni;
    logic       Out_Valid;
    logic       Done;
    logic       Stall;
    logic       Illegal;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    typedef struct {
        logic [3:0] op;
        logic       ov;
        logic       dn;
        logic       st;
        logic       il;
    } exp_t;

    exp_t sb[$];

    alu_control_sekuencial #(
        .FUNCT_W   (6),
        .OP_W      (4),
        .MUL_CYCLES(4),
        .ROR_CYCLES(3)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .Operacioni(Operacioni),
        .Out_Valid (Out_Valid),
        .Done      (Done),
        .Stall     (Stall),
        .Illegal   (Illegal)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus, queue the outputs expected after the edge,
    // then pop and compare once the DUT has produced them.
    task automatic step(input logic rst, input logic iv, input logic [1:0] aop,
                        input logic [5:0] fn, input logic [3:0] eop, input logic eov,
                        input logic edn, input logic est, input logic eil);
        exp_t e;
        Reset    = rst;
        In_Valid = iv;
        ALUOp    = aop;
        Funct    = fn;
        e.op = eop; e.ov = eov; e.dn = edn; e.st = est; e.il = eil;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        stepno++;
        e = sb.pop_front();
        checks++;
        assert (Operacioni === e.op) else begin
            errors++;
            $error("FAIL step%0d Operacioni got %b want %b", stepno, Operacioni, e.op);
        end
        checks++;
        assert (Out_Valid === e.ov) else begin
            errors++;
            $error("FAIL step%0d Out_Valid got %b want %b", stepno, Out_Valid, e.ov);
        end
        checks++;
        assert (Done === e.dn) else begin
            errors++;
            $error("FAIL step%0d Done got %b want %b", stepno, Done, e.dn);
        end
        checks++;
        assert (Stall === e.st) else begin
            errors++;
            $error("FAIL step%0d Stall got %b want %b", stepno, Stall, e.st);
        end
        checks++;
        assert (Illegal === e.il) else begin
            errors++;
            $error("FAIL step%0d Illegal got %b want %b", stepno, Illegal, e.il);
        end
    endtask

    initial begin
        Reset = 1'b1; In_Valid = 1'b0; ALUOp = 2'b00; Funct = 6'd0;
        #2;
        // reset and idle
        step(1, 0, 2'b00, 6'd0, 4'b1111, 0, 0, 0, 0);
        step(1, 1, 2'b00, 6'd0, 4'b1111, 0, 0, 0, 0);
        step(0, 0, 2'b00, 6'd0, 4'b1111, 0, 0, 0, 0);
        // single-cycle ops back to back
        step(0, 1, 2'b00, 6'd0, 4'b0100, 1, 1, 0, 0);
        step(0, 1, 2'b01, 6'd0, 4'b1100, 1, 1, 0, 0);
        step(0, 1, 2'b10, 6'd0, 4'b0000, 1, 1, 0, 0);
        step(0, 1, 2'b10, 6'd1, 4'b0010, 1, 1, 0, 0);
        step(0, 1, 2'b10, 6'd2, 4'b0011, 1, 1, 0, 0);
        step(0, 1, 2'b10, 6'd5, 4'b0101, 1, 1, 0, 0);
        // idle: code holds, valid drops
        step(0, 0, 2'b00, 6'd0, 4'b0101, 0, 0, 0, 0);
        // mul for 4 cycles; inputs during the stall are ignored
        step(0, 1, 2'b10, 6'd4, 4'b0111, 1, 0, 1, 0);
        step(0, 1, 2'b11, 6'd0, 4'b0111, 1, 0, 1, 0);
        step(0, 1, 2'b00, 6'd0, 4'b0111, 1, 0, 1, 0);
        step(0, 1, 2'b00, 6'd0, 4'b0111, 1, 1, 0, 0);
        step(0, 1, 2'b00, 6'd0, 4'b0100, 1, 1, 0, 0);
        // ror for 3 cycles, then and with no bubble
        step(0, 1, 2'b10, 6'd3, 4'b0110, 1, 0, 1, 0);
        step(0, 1, 2'b10, 6'd0, 4'b0110, 1, 0, 1, 0);
        step(0, 1, 2'b10, 6'd0, 4'b0110, 1, 1, 0, 0);
        step(0, 1, 2'b10, 6'd0, 4'b0000, 1, 1, 0, 0);
        // illegal instructions
        step(0, 1, 2'b11, 6'd0, 4'b1111, 0, 0, 0, 1);
        step(0, 0, 2'b00, 6'd0, 4'b1111, 0, 0, 0, 0);
        step(0, 1, 2'b10, 6'b001111, 4'b1111, 0, 0, 0, 1);
        step(0, 1, 2'b10, 6'b010000, 4'b1111, 0, 0, 0, 1);
        step(0, 0, 2'b00, 6'd0, 4'b1111, 0, 0, 0, 0);
        step(0, 1, 2'b10, 6'b100001, 4'b1111, 0, 0, 0, 1);
        step(0, 1, 2'b00, 6'd0, 4'b0100, 1, 1, 0, 0);
        // reset in cycle 2 of a mul, then a sub
        step(0, 1, 2'b10, 6'd4, 4'b0111, 1, 0, 1, 0);
        step(1, 1, 2'b10, 6'd4, 4'b1111, 0, 0, 0, 0);
        step(0, 1, 2'b01, 6'd0, 4'b1100, 1, 1, 0, 0);
        step(0, 0, 2'b00, 6'd0, 4'b1100, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
